// File: rtl/jtkunio_ram_arb.sv
// jtkunio_ram_arb
// The main 6502 bus and the character tile fetcher share one port of the
// 8kB work/char RAM. Char VRAM is the top 2kB of the same chips. Each
// requester sends a one-cycle req strobe. The block runs one RAM access at
// a time through a small IDLE -> ACC -> DONE sequence.
//
// Handshake: a req strobe is a one-cycle pulse, and there is no ready signal
// back to the requester. The strobe always lands in that requester's capture
// slot. A newer strobe overwrites a slot that is waiting and not yet granted.
// The slot is copied into the RAM-side registers at grant time, so a strobe
// that arrives during service is kept as pending and served next.
// Completion: cpu_ok is a level that stays high until the next cpu_req.
// vid_ok is a one-cycle pulse that marks vid_data valid.

module jtkunio_ram_arb #(
    parameter logic [12:0] VRAM_BASE = 13'h1800,
    parameter int unsigned RD_LAT    = 1,
    parameter bit          VID_PRIO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ok,
    input  logic        vid_req,
    input  logic [10:0] vid_addr,
    output logic [7:0]  vid_data,
    output logic        vid_ok,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Read wait in ACC, counted in cycles after the address is presented.
    localparam logic [1:0] LAT = RD_LAT[1:0];

    logic [1:0]  state;
    logic [1:0]  wait_cnt;

    // Capture slots
    logic        cpu_pend;
    logic        cpu_rnw_q;
    logic [12:0] cpu_addr_q;
    logic [7:0]  cpu_dout_q;
    logic        vid_pend;
    logic [10:0] vid_addr_q;

    // Access in flight
    logic        act_vid;
    logic        act_rnw;

    // 1 = video was the last requester served
    logic        last_vid;

    logic        grant_vid;
    logic [12:0] vid_ram_addr;

    // Pick the winner of the next grant. When both are pending, fixed
    // priority hands the port to video. Round-robin hands it to whichever
    // requester was not served last.
    always_comb begin
        grant_vid = 1'b0;
        if (vid_pend) begin
            if (!cpu_pend)
                grant_vid = 1'b1;
            else if (VID_PRIO)
                grant_vid = 1'b1;
            else
                grant_vid = !last_vid;
        end
    end

    // The video offset wraps inside the 13-bit RAM space, with no carry out.
    always_comb begin
        vid_ram_addr = VRAM_BASE + {2'b00, vid_addr_q};
    end

    // Run the access sequencer, the capture slots and the completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            cpu_pend   <= 1'b0;
            cpu_rnw_q  <= 1'b0;
            cpu_addr_q <= 13'd0;
            cpu_dout_q <= 8'd0;
            vid_pend   <= 1'b0;
            vid_addr_q <= 11'd0;
            act_vid    <= 1'b0;
            act_rnw    <= 1'b0;
            last_vid   <= 1'b1;
            cpu_din    <= 8'd0;
            cpu_ok     <= 1'b1;
            vid_data   <= 8'd0;
            vid_ok     <= 1'b0;
            ram_addr   <= 13'd0;
            ram_din    <= 8'd0;
            ram_we     <= 1'b0;
        end else begin
            vid_ok <= 1'b0;
            ram_we <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cpu_pend || vid_pend) begin
                        act_vid  <= grant_vid;
                        wait_cnt <= 2'd0;
                        state    <= ST_ACC;
                        if (grant_vid) begin
                            // Video is read-only, so there is no write strobe.
                            ram_addr <= vid_ram_addr;
                            act_rnw  <= 1'b1;
                            vid_pend <= 1'b0;
                        end else begin
                            ram_addr <= cpu_addr_q;
                            ram_din  <= cpu_dout_q;
                            ram_we   <= !cpu_rnw_q;
                            act_rnw  <= cpu_rnw_q;
                            cpu_pend <= 1'b0;
                        end
                    end
                end
                ST_ACC: begin
                    // A write needs only its single strobe cycle. A read
                    // holds the address until the RAM data is valid.
                    if (!act_rnw || wait_cnt == LAT)
                        state <= ST_DONE;
                    else
                        wait_cnt <= wait_cnt + 2'd1;
                end
                ST_DONE: begin
                    if (act_vid) begin
                        vid_data <= ram_dout;
                        vid_ok   <= 1'b1;
                    end else begin
                        if (act_rnw)
                            cpu_din <= ram_dout;
                        cpu_ok <= 1'b1;
                    end
                    last_vid <= act_vid;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Strobes are captured last, so they override a grant-time
            // pend clear and a same-edge cpu_ok set.
            if (cpu_req) begin
                cpu_pend   <= 1'b1;
                cpu_rnw_q  <= cpu_rnw;
                cpu_addr_q <= cpu_addr;
                cpu_dout_q <= cpu_dout;
                cpu_ok     <= 1'b0;
            end
            if (vid_req) begin
                vid_pend   <= 1'b1;
                vid_addr_q <= vid_addr;
            end
        end
    end

endmodule
